// File: rtl/mpu_pkg.sv
// MPU9250 register map constants and scheduler state encoding shared by
// the sample scheduler and its tick generator.
package mpu_pkg;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
    localparam logic [7:0] READ_FLAG    = 8'h80;

    // Largest frame: accel XYZ, temp, gyro XYZ -> 7 words / 14 bytes.
    localparam int MAX_BYTES = 14;
    localparam int NUM_WORDS = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_COMMIT = 3'd4
    } sched_state_t;

    // SPI read address: read flag in the MSB, 7-bit register below it.
    function automatic logic [7:0] read_addr(input logic [7:0] reg_addr);
        return READ_FLAG | {1'b0, reg_addr[6:0]};
    endfunction

endpackage

// File: rtl/mpu_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while enabled and flags the
// wrap cycle as a sample tick. Disabling parks the counter at zero so the
// first tick after enabling is a full period away.
module mpu_tick_gen
    import mpu_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running period counter, held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_mpu_sched.sv
// Periodic MPU9250 burst reader. On each sample tick it walks NUM_BYTES
// registers from BASE_ADDR through an external single-byte SPI reader,
// collects them in a shadow buffer and publishes the whole frame as
// big-endian 16-bit words in one cycle together with a valid pulse.
//
// Reader handshake: get_start is a one-cycle request, issued only while
// get_busy is low; get_addr is held from that cycle until the matching
// get_finish, which is a one-cycle pulse qualifying get_data. A finish
// seen outside the wait state belongs to no request and is discarded.
// The scheduler state is the enum register 'state'.
module spi_mpu_sched
    import mpu_pkg::*;
#(
    parameter int          SAMPLE_DIV = 50000,
    parameter logic [7:0]  BASE_ADDR  = ACCEL_XOUT_H,
    parameter int          NUM_BYTES  = 14,
    parameter int          TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        get_start,
    output logic [7:0]  get_addr,
    input  logic        get_busy,
    input  logic        get_finish,
    input  logic [7:0]  get_data,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic [15:0] az,
    output logic [15:0] temp,
    output logic [15:0] gx,
    output logic [15:0] gy,
    output logic [15:0] gz,
    output logic        valid,
    output logic        overrun,
    output logic        timeout
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);
    localparam logic [3:0]     LAST_IDX   = 4'(NUM_BYTES - 1);

    sched_state_t   state;
    logic [3:0]     idx;
    logic [WCW-1:0] wait_cnt;
    logic [7:0]     shadow [MAX_BYTES];
    logic [15:0]    word_q [NUM_WORDS];
    logic           tick;

    mpu_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Frame sequencer: issue one byte read at a time, commit the frame atomically.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            get_start <= 1'b0;
            get_addr  <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) shadow[i] <= '0;
            for (int k = 0; k < NUM_WORDS; k++) word_q[k] <= '0;
        end else begin
            get_start <= 1'b0;
            valid     <= 1'b0;

            // Any tick the sequencer cannot take is dropped but remembered.
            if (tick && state != S_IDLE) overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick && en) begin
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!get_busy) begin
                        get_start <= 1'b1;
                        get_addr  <= read_addr(BASE_ADDR + 8'(idx));
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (get_finish) begin
                        shadow[idx] <= get_data;
                        state       <= S_NEXT;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // Abandon the frame; published words keep the last good frame.
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            word_q[k] <= (2 * k + 1 < NUM_BYTES) ?
                                         {shadow[2 * k], shadow[2 * k + 1]} : 16'h0000;
                        end
                        valid <= 1'b1;
                        state <= S_COMMIT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ax   = word_q[0];
    assign ay   = word_q[1];
    assign az   = word_q[2];
    assign temp = word_q[3];
    assign gx   = word_q[4];
    assign gy   = word_q[5];
    assign gz   = word_q[6];

endmodule
